// File: rtl/carry_chain.sv
// rtl/carry_chain.sv - registered mux-carry ripple chain with optional signed-overflow flag (macro CARRY_CHAIN_OVF_EN)
module carry_chain #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             CIN,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
`ifdef CARRY_CHAIN_OVF_EN
    output logic             VALID,
    output logic             OVF
`else
    output logic             VALID
`endif
);

    // Carry vector: carry[0] is CIN, carry[i+1] leaves cell i.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] o_q, o_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;
`ifdef CARRY_CHAIN_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Ripple the carry from CIN through every cell, no register in the path.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = CIN;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = P[i] ^ carry[i];
            carry[i+1] = P[i] ? carry[i] : G[i];
        end
    end

    // Load a fresh result when enabled, otherwise hold the data and drop VALID.
    always_comb begin
        o_d     = o_q;
        cout_d  = cout_q;
        valid_d = EN;
`ifdef CARRY_CHAIN_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (EN) begin
            o_d    = sum;
            cout_d = carry[WIDTH];
`ifdef CARRY_CHAIN_OVF_EN
            ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
`endif
        end
    end

    // Output registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            o_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef CARRY_CHAIN_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            o_q     <= o_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef CARRY_CHAIN_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign O     = o_q;
    assign COUT  = cout_q;
    assign VALID = valid_q;
`ifdef CARRY_CHAIN_OVF_EN
    assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_carry_chain.sv
// tb/tb_carry_chain.sv - scoreboard bench for carry_chain at WIDTH=8 and WIDTH=1
module tb_carry_chain;

    typedef struct packed {
        logic [7:0] o;
        logic       cout;
        logic       valid;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en8 = 1'b0;
    logic [7:0] p8 = '0, g8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] o8;
    logic       cout8, valid8;

    logic       en1 = 1'b0;
    logic [0:0] p1 = '0, g1 = '0;
    logic       cin1 = 1'b0;
    logic [0:0] o1;
    logic       cout1, valid1;

`ifdef CARRY_CHAIN_OVF_EN
    logic       ovf8, ovf1;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t sb8[$];
    exp_t sb1[$];
    exp_t last8 = '0;

    always #5 clk = ~clk;

    carry_chain #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET(rst), .EN(en8), .P(p8), .G(g8), .CIN(cin8),
        .O(o8), .COUT(cout8),
`ifdef CARRY_CHAIN_OVF_EN
        .VALID(valid8), .OVF(ovf8)
`else
        .VALID(valid8)
`endif
    );

    carry_chain #(.WIDTH(1)) dut1 (
        .CLK(clk), .RESET(rst), .EN(en1), .P(p1), .G(g1), .CIN(cin1),
        .O(o1), .COUT(cout1),
`ifdef CARRY_CHAIN_OVF_EN
        .VALID(valid1), .OVF(ovf1)
`else
        .VALID(valid1)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model8(input logic [7:0] p, input logic [7:0] g, input logic cin);
        exp_t e;
        logic c, c_prev;
        e = '0;
        c = cin;
        c_prev = cin;
        for (int i = 0; i < 8; i++) begin
            e.o[i] = p[i] ^ c;
            c_prev = c;
            c = p[i] ? c : g[i];
        end
        e.cout  = c;
        e.ovf   = c ^ c_prev;
        e.valid = 1'b1;
        return e;
    endfunction

    task automatic chk8(input string tag, input exp_t e);
        tests++;
        assert (o8 === e.o) else begin
            fails++; $error("FAIL %s O: got %h expected %h", tag, o8, e.o);
        end
        tests++;
        assert (cout8 === e.cout) else begin
            fails++; $error("FAIL %s COUT: got %b expected %b", tag, cout8, e.cout);
        end
        tests++;
        assert (valid8 === e.valid) else begin
            fails++; $error("FAIL %s VALID: got %b expected %b", tag, valid8, e.valid);
        end
`ifdef CARRY_CHAIN_OVF_EN
        tests++;
        assert (ovf8 === e.ovf) else begin
            fails++; $error("FAIL %s OVF: got %b expected %b", tag, ovf8, e.ovf);
        end
`endif
    endtask

    // Drive one cycle on the WIDTH=8 instance, push the expectation, compare after the edge.
    task automatic step8(input string tag, input logic [7:0] p, input logic [7:0] g,
                         input logic cin, input logic en);
        exp_t e;
        if (en) e = model8(p, g, cin);
        else begin
            e = last8;
            e.valid = 1'b0;
        end
        last8 = e;
        sb8.push_back(e);
        p8 = p; g8 = g; cin8 = cin; en8 = en;
        @(posedge clk);
        #1;
        chk8(tag, sb8.pop_front());
    endtask

    initial begin
        exp_t e;
        logic [7:0] a, b;

        // Reset state, asynchronous (no clock edge needed).
        #2;
        e = '0;
        chk8("reset8", e);
        tests++;
        assert ({o1, cout1, valid1} === 3'b000) else begin
            fails++; $error("FAIL reset1: got %b expected 000", {o1, cout1, valid1});
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Exhaustive WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            exp_t e1;
            v = i[2:0];
            e1 = '0;
            e1.o[0] = v[2] ^ v[0];
            e1.cout = v[2] ? v[0] : v[1];
            e1.valid = 1'b1;
            e1.ovf = e1.cout ^ v[0];
            sb1.push_back(e1);
            p1 = v[2]; g1 = v[1]; cin1 = v[0]; en1 = 1'b1;
            @(posedge clk); #1;
            e1 = sb1.pop_front();
            tests++;
            assert ({o1, cout1, valid1} === {e1.o[0], e1.cout, e1.valid}) else begin
                fails++; $error("FAIL w1_%0d: got %b expected %b", i, {o1, cout1, valid1},
                                {e1.o[0], e1.cout, e1.valid});
            end
`ifdef CARRY_CHAIN_OVF_EN
            tests++;
            assert (ovf1 === e1.ovf) else begin
                fails++; $error("FAIL w1_ovf_%0d: got %b expected %b", i, ovf1, e1.ovf);
            end
`endif
        end
        en1 = 1'b0;

        // Directed WIDTH=8 cases, back-to-back enabled cycles.
        step8("full_prop", 8'hFF, 8'h00, 1'b1, 1'b1);
        tests++;
        assert ({o8, cout8, valid8} === {8'h00, 1'b1, 1'b1}) else begin
            fails++; $error("FAIL full_prop_const: got %h/%b/%b expected 00/1/1", o8, cout8, valid8);
        end
        step8("add_0f_01", 8'h0E, 8'h01, 1'b0, 1'b1);
        tests++;
        assert ({o8, cout8} === {8'h10, 1'b0}) else begin
            fails++; $error("FAIL add_0f_01_const: got %h/%b expected 10/0", o8, cout8);
        end
        step8("add_ff_01", 8'hFE, 8'h01, 1'b0, 1'b1);
        tests++;
        assert ({o8, cout8} === {8'h00, 1'b1}) else begin
            fails++; $error("FAIL add_ff_01_const: got %h/%b expected 00/1", o8, cout8);
        end
`ifdef CARRY_CHAIN_OVF_EN
        tests++;
        assert (ovf8 === 1'b0) else begin
            fails++; $error("FAIL add_ff_01_ovf: got %b expected 0", ovf8);
        end
`endif
        step8("ovf_7f_01", 8'h7E, 8'h01, 1'b0, 1'b1);
        tests++;
        assert ({o8, cout8} === {8'h80, 1'b0}) else begin
            fails++; $error("FAIL ovf_7f_01_const: got %h/%b expected 80/0", o8, cout8);
        end
`ifdef CARRY_CHAIN_OVF_EN
        tests++;
        assert (ovf8 === 1'b1) else begin
            fails++; $error("FAIL ovf_7f_01_ovf: got %b expected 1", ovf8);
        end
`endif

        // Arithmetic cross-check: P=A^B, G=A&B against A+B+CIN.
        for (int i = 0; i < 6; i++) begin
            logic [8:0] s;
            logic       ci;
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            step8("add_rand", a ^ b, a & b, ci, 1'b1);
            tests++;
            assert ({cout8, o8} === s) else begin
                fails++; $error("FAIL add_sum_%0d: got %h expected %h", i, {cout8, o8}, s);
            end
        end

        // Hold: capture, then disable and change inputs.
        step8("capture", 8'h3C, 8'h81, 1'b1, 1'b1);
        step8("hold_a", 8'hA5, 8'h5A, 1'b0, 1'b0);
        step8("hold_b", 8'h00, 8'hFF, 1'b1, 1'b0);

        // Reset mid-stream between edges while VALID=1.
        step8("pre_reset", 8'h55, 8'h22, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        e = '0;
        chk8("mid_reset", e);
        last8 = '0;
        @(negedge clk);
        rst = 1'b0;

        // 101 random vectors against the mux-carry model.
        for (int i = 0; i < 101; i++)
            step8("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
